// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters with sync, data-enable and
// frame-event pulses, every output registered and decoded from the next state.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 29,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic             clk25,
  input  logic             reset_n,
  input  logic             en,
  output logic [CNT_W-1:0] xpos,
  output logic [CNT_W-1:0] ypos,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line_start,
  output logic             frame_start,
  output logic             end_of_active,
  output logic [7:0]       frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W)) begin : g_size_check
    $error("video_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HS_BEG     = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG     = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                     input logic [CNT_W-1:0] beg,
                                     input logic [CNT_W-1:0] fin);
    return (pos >= beg) && (pos < fin);
  endfunction

  logic [CNT_W-1:0] xpos_nxt;
  logic [CNT_W-1:0] ypos_nxt;
  logic             line_wrap;
  logic             frame_wrap;
  logic             active_end;

  // Next-state counters; the registered outputs below decode from these so
  // that sync/de land in the same cycle as the position they describe.
  always_comb begin
    xpos_nxt  = xpos;
    ypos_nxt  = ypos;
    line_wrap = 1'b0;
    if (en) begin
      if (xpos == H_LAST) begin
        xpos_nxt  = '0;
        line_wrap = 1'b1;
        ypos_nxt  = (ypos == V_LAST) ? '0 : ypos + CNT_W'(1);
      end else begin
        xpos_nxt = xpos + CNT_W'(1);
      end
    end
  end

  assign frame_wrap = line_wrap && (ypos == V_LAST);
  assign active_end = line_wrap && (ypos == V_ACT_LAST);

  always_ff @(posedge clk25) begin
    if (!reset_n) begin
      xpos          <= '0;
      ypos          <= '0;
      hsync         <= ~H_POL;
      vsync         <= ~V_POL;
      de            <= 1'b1;
      line_start    <= 1'b0;
      frame_start   <= 1'b0;
      end_of_active <= 1'b0;
      frame_count   <= '0;
    end else begin
      xpos          <= xpos_nxt;
      ypos          <= ypos_nxt;
      hsync         <= in_window(xpos_nxt, HS_BEG, HS_END) ? H_POL : ~H_POL;
      vsync         <= in_window(ypos_nxt, VS_BEG, VS_END) ? V_POL : ~V_POL;
      de            <= (xpos_nxt < H_ACT) && (ypos_nxt < V_ACT);
      line_start    <= line_wrap;
      frame_start   <= frame_wrap;
      end_of_active <= active_end;
      if (frame_wrap) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on the reduced 14x7 raster: hand vectors, a
// reference-model scoreboard, and period / per-frame count checks.
module tb_video_timing_gen;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
    logic       eoa;
    logic [7:0] fc;
  } out_t;

  typedef struct {
    logic r;
    logic e;
    out_t exp;
  } vec_t;

  logic       clk25 = 1'b0;
  logic       reset_n;
  logic       en;
  logic [3:0] xpos;
  logic [3:0] ypos;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic       line_start;
  logic       frame_start;
  logic       end_of_active;
  logic [7:0] frame_count;

  int checks = 0;
  int errors = 0;

  out_t exp_q[$];
  vec_t tbl[$];

  logic [3:0] mx, my;
  logic [7:0] mfc;

  int cyc = 0;
  logic meas = 1'b0;
  int last_ls, last_fs, de_cnt, vs_cnt, eoa_cnt;
  logic [7:0] prev_fc = 8'd0;
  logic fc_wrapped = 1'b0;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b0), .CNT_W(4)
  ) dut (
    .clk25(clk25),
    .reset_n(reset_n),
    .en(en),
    .xpos(xpos),
    .ypos(ypos),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .line_start(line_start),
    .frame_start(frame_start),
    .end_of_active(end_of_active),
    .frame_count(frame_count)
  );

  always #5 clk25 = ~clk25;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  function automatic out_t mk(input int x, input int y, input logic hs, input logic vs,
                              input logic d, input logic ls, input logic fs,
                              input logic eoa, input int fc);
    out_t o;
    o.x = 4'(x); o.y = 4'(y); o.hs = hs; o.vs = vs; o.de = d;
    o.ls = ls; o.fs = fs; o.eoa = eoa; o.fc = 8'(fc);
    return o;
  endfunction

  task automatic add(input logic r, input logic e, input out_t o);
    vec_t v;
    v.r = r; v.e = e; v.exp = o;
    tbl.push_back(v);
  endtask

  task automatic monitor();
    if (prev_fc == 8'd255 && frame_count == 8'd0) fc_wrapped = 1'b1;
    prev_fc = frame_count;
    if (!meas) return;
    if (line_start) begin
      if (last_ls >= 0) chk("line_period", cyc - last_ls, 14);
      last_ls = cyc;
    end
    if (frame_start) begin
      if (last_fs >= 0) begin
        chk("frame_period", cyc - last_fs, 98);
        chk("de_per_frame", de_cnt, 32);
        chk("vsync_low_per_frame", vs_cnt, 14);
        chk("eoa_per_frame", eoa_cnt, 1);
      end
      last_fs = cyc;
      de_cnt = 0; vs_cnt = 0; eoa_cnt = 0;
    end
    de_cnt  += int'(de);
    vs_cnt  += int'(!vsync);
    eoa_cnt += int'(end_of_active);
  endtask

  task automatic cycle(input logic r, input logic e, input out_t exp);
    out_t act, want;
    reset_n = r;
    en = e;
    exp_q.push_back(exp);
    @(posedge clk25);
    #1;
    cyc++;
    act = {xpos, ypos, hsync, vsync, de, line_start, frame_start, end_of_active, frame_count};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got=%h want=none", act);
    end else begin
      want = exp_q.pop_front();
      if (act !== want) begin
        errors++;
        $display("FAIL outputs cyc=%0d got=%h want=%h", cyc, act, want);
      end
    end
    monitor();
  endtask

  function automatic out_t model_out(input logic ls, input logic fs, input logic eoa);
    return mk(int'(mx), int'(my), (mx >= 4'd10 && mx <= 4'd12), (my != 4'd5),
              (mx < 4'd8 && my < 4'd4), ls, fs, eoa, int'(mfc));
  endfunction

  task automatic mcycle(input logic r, input logic e);
    logic ls, fs, eoa;
    ls = 1'b0; fs = 1'b0; eoa = 1'b0;
    if (!r) begin
      mx = 4'd0; my = 4'd0; mfc = 8'd0;
    end else if (e) begin
      if (mx == 4'd13) begin
        mx  = 4'd0;
        my  = (my == 4'd6) ? 4'd0 : my + 4'd1;
        ls  = 1'b1;
        fs  = (my == 4'd0);
        eoa = (my == 4'd4);
        if (fs) mfc = mfc + 8'd1;
      end else begin
        mx = mx + 4'd1;
      end
    end
    cycle(r, e, model_out(ls, fs, eoa));
  endtask

  task automatic start_meas();
    meas = 1'b1;
    last_ls = -1; last_fs = -1;
    de_cnt = 0; vs_cnt = 0; eoa_cnt = 0;
  endtask

  initial begin
    int n;
    logic found;
    reset_n = 1'b0;
    en = 1'b0;

    // Hand-derived vectors: reset, first advance, stalls, sync edges, wrap.
    add(1'b0, 1'b1, mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    add(1'b0, 1'b0, mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    add(1'b1, 1'b0, mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    add(1'b1, 1'b1, mk(1, 0, 0, 1, 1, 0, 0, 0, 0));
    add(1'b1, 1'b0, mk(1, 0, 0, 1, 1, 0, 0, 0, 0));
    for (int x = 2; x <= 7; x++) add(1'b1, 1'b1, mk(x, 0, 0, 1, 1, 0, 0, 0, 0));
    add(1'b1, 1'b1, mk(8, 0, 0, 1, 0, 0, 0, 0, 0));
    add(1'b1, 1'b1, mk(9, 0, 0, 1, 0, 0, 0, 0, 0));
    add(1'b1, 1'b1, mk(10, 0, 1, 1, 0, 0, 0, 0, 0));
    add(1'b1, 1'b0, mk(10, 0, 1, 1, 0, 0, 0, 0, 0));
    add(1'b1, 1'b1, mk(11, 0, 1, 1, 0, 0, 0, 0, 0));
    add(1'b1, 1'b1, mk(12, 0, 1, 1, 0, 0, 0, 0, 0));
    add(1'b1, 1'b1, mk(13, 0, 0, 1, 0, 0, 0, 0, 0));
    add(1'b1, 1'b0, mk(13, 0, 0, 1, 0, 0, 0, 0, 0));
    add(1'b1, 1'b1, mk(0, 1, 0, 1, 1, 1, 0, 0, 0));
    add(1'b1, 1'b1, mk(1, 1, 0, 1, 1, 0, 0, 0, 0));
    add(1'b0, 1'b1, mk(0, 0, 0, 1, 1, 0, 0, 0, 0));

    repeat (2) @(posedge clk25);
    #1;
    foreach (tbl[i]) cycle(tbl[i].r, tbl[i].e, tbl[i].exp);

    // Free run from reset: two-plus frames with period and per-frame counts.
    repeat (3) mcycle(1'b0, 1'b1);
    start_meas();
    repeat (2 * 98 + 30) mcycle(1'b1, 1'b1);
    meas = 1'b0;

    // Random 50% enable: stalls must hold everything and suppress pulses.
    repeat (600) mcycle(1'b1, 1'($urandom_range(0, 1)));

    // Mid-frame reset at (5,2), then time the next frame_start.
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (mx == 4'd5 && my == 4'd2) begin
        found = 1'b1;
        break;
      end
      mcycle(1'b1, 1'b1);
    end
    chk("reach_5_2", int'(found), 1);
    repeat (3) mcycle(1'b0, 1'b1);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      mcycle(1'b1, 1'b1);
      if (frame_start) begin
        n = i;
        break;
      end
    end
    chk("restart_period", n, 98);

    // Long run through the frame_count 255 -> 0 wrap.
    start_meas();
    repeat (256 * 98 + 20) mcycle(1'b1, 1'b1);
    meas = 1'b0;
    chk("fc_wrap_seen", int'(fc_wrapped), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, meaning horizontal front porch in clocks.
REQ-003 The block SHALL have parameter H_SYNC, default 96, meaning hsync pulse width in clocks.
REQ-004 The block SHALL have parameter H_BP, default 48, meaning horizontal back porch in clocks.
REQ-005 The block SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 10, meaning vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, meaning vsync pulse width in lines.
REQ-008 The block SHALL have parameter V_BP, default 29, meaning vertical back porch in lines.
REQ-009 The block SHALL have parameter H_POL, default 0, meaning hsync asserted level (0 = active-low).
REQ-010 The block SHALL have parameter V_POL, default 0, meaning vsync asserted level (0 = active-low).
REQ-011 The block SHALL have parameter CNT_W, default 10, meaning width of xpos/ypos.
REQ-012 The block SHALL have port clk25, input, 1, meaning pixel clock (one clock; all logic on its rising edge).
REQ-013 The block SHALL have port reset_n, input, 1, meaning synchronous active-low reset.
REQ-014 The block SHALL have port en, input, 1, meaning pixel advance enable.
REQ-015 The block SHALL have port xpos, output, CNT_W, meaning current pixel column.
REQ-016 The block SHALL have port ypos, output, CNT_W, meaning current line.
REQ-017 The block SHALL have port hsync, output, 1, meaning horizontal sync at H_POL when asserted.
REQ-018 The block SHALL have port vsync, output, 1, meaning vertical sync at V_POL when asserted.
REQ-019 The block SHALL have port de, output, 1, meaning visible-area flag.
REQ-020 The block SHALL have port line_start, output, 1, meaning one-cycle pulse at xpos wrap.
REQ-021 The block SHALL have port frame_start, output, 1, meaning one-cycle pulse at (0,0) wrap.
REQ-022 The block SHALL have port end_of_active, output, 1, meaning one-cycle pulse on entering (0,V_ACTIVE).
REQ-023 The block SHALL have port frame_count, output, 8, meaning completed-frame counter.

Function
REQ-024 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; both SHALL fit in CNT_W bits, else elaboration error.
REQ-025 All outputs SHALL be driven directly from flops, with no combinational path from inputs.
REQ-026 With en=1: xpos SHALL increment by 1 per clock and wrap H_TOTAL-1 -> 0; on that wrap, ypos SHALL increment by 1 and wrap V_TOTAL-1 -> 0.
REQ-027 With en=0: all counters and level outputs SHALL hold, and line_start, frame_start and end_of_active SHALL be 0.
REQ-028 hsync SHALL equal H_POL exactly when H_ACTIVE+H_FP <= xpos < H_ACTIVE+H_FP+H_SYNC, and ~H_POL otherwise, in the same cycle as that xpos (zero relative latency; decode from next-state).
REQ-029 vsync SHALL equal V_POL exactly when V_ACTIVE+V_FP <= ypos < V_ACTIVE+V_FP+V_SYNC, for the whole line including xpos=0, and ~V_POL otherwise.
REQ-030 de SHALL be 1 exactly when xpos < H_ACTIVE and ypos < V_ACTIVE, aligned with xpos/ypos.
REQ-031 line_start SHALL be 1 for the single cycle in which xpos==0 following an en=1 wrap.
REQ-032 frame_start SHALL be 1 for the single cycle in which (xpos,ypos)==(0,0) following an en=1 wrap.
REQ-033 end_of_active SHALL be 1 for the single cycle in which (xpos,ypos)==(0,V_ACTIVE) is entered.
REQ-034 frame_count SHALL increment by 1 on each frame_start, in the same cycle, wrapping 255 -> 0.
REQ-035 When en is held high, the pulse period SHALL be H_TOTAL clocks for line_start and H_TOTAL*V_TOTAL clocks for frame_start.

Reset
REQ-036 With reset_n=0 at a clk25 edge, the next state SHALL be xpos=0, ypos=0, frame_count=0, hsync=~H_POL, vsync=~V_POL, de=1, line_start=0, frame_start=0, end_of_active=0, regardless of en.
REQ-037 Reset mid-frame SHALL abort the frame immediately, with no frame_start pulse and no frame_count increment.
REQ-038 In the first en=1 cycle after release, the block SHALL advance to xpos=1.

Verification
REQ-039 Defaults, en=1, reset then run 2 frames -> line_start every 800 clocks; frame_start every 416800 clocks; frame_count 0->1->2; hsync low for xpos 656..751 only.
REQ-040 Defaults -> vsync low for every clock of ypos 490..491 only; de high for exactly 307200 clocks per frame; end_of_active at (0,480) once per frame.
REQ-041 Toggle en in a random 50% pattern -> counter sequence identical to the en=1 sequence with stalls; no pulse is ever seen while en=0; no pulse is duplicated.
REQ-042 Assert reset_n=0 at (xpos,ypos)=(300,200) for 3 clocks -> outputs match the REQ-036 values; the next frame_start comes 416800 enabled clocks after release.
REQ-043 Parameters H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, H_POL=1, CNT_W=4 -> hsync high at xpos 10..12; line period 14; frame period 98; frame_count wraps 255->0 after 256 frames.
